// File: rtl/data_memory.sv
// data_memory: word-addressed data RAM with registered (1-cycle) read data,
// a sticky access-fault flag, and an optional MMIO register block.
//
// Build option: define DATA_MEMORY_MMIO_EN to compile in the MMIO block
// (CYCLES counter, SCRATCH register, STATUS register at 0xFFFFFF00..0x08).
// Without it, the 0xFFFFFF00 page is unmapped and mem_error clears only on reset.
//
// Address map (byte addresses, word aligned):
//   0x0000_0000 .. 4*DEPTH_WORDS-1 : RAM
//   0xFFFF_FF00 + 0x00             : CYCLES  (read-only free-running counter)
//   0xFFFF_FF00 + 0x04             : SCRATCH (read/write)
//   0xFFFF_FF00 + 0x08             : STATUS  (bit0 mem_error W1C, bit1 count enable)
//   anything else                  : unmapped (reads 0, writes fault)

module data_memory #(
  parameter int DEPTH_WORDS        = 256,
  parameter bit RESET_COUNT_EN_VAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [31:0] WriteAddress,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        mem_error
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  // Which registered source drives ReadData in the cycle after an access.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_MMIO = 2'd2
  } src_e;

  // ---------------------------------------------------------------------------
  // Stage p0: address decode of the current request (combinational)
  // ---------------------------------------------------------------------------
  logic             aligned_p0;
  logic             ram_hit_p0;
  logic             mmio_hit_p0;
  logic             fault_p0;
  logic             ram_we_p0;
  logic             err_clr_p0;
  logic [IDX_W-1:0] idx_p0;
  src_e             src_p0;

  assign aligned_p0 = (WriteAddress[1:0] == 2'b00);
  assign ram_hit_p0 = (WriteAddress < RAM_BYTES);
  assign idx_p0     = WriteAddress[IDX_W+1:2];

`ifdef DATA_MEMORY_MMIO_EN
  assign mmio_hit_p0 = (WriteAddress[31:8] == 24'hFF_FFFF);
`else
  assign mmio_hit_p0 = 1'b0;
`endif

  // A store faults when it is misaligned or lands outside every mapped region.
  assign fault_p0 = write_enable && (!aligned_p0 || (!ram_hit_p0 && !mmio_hit_p0));

  // The reset term makes a store coinciding with reset assertion a no-op.
  assign ram_we_p0 = write_enable && aligned_p0 && ram_hit_p0 && reset;

  // Select the read source for this access; faulting reads return zero.
  always_comb begin
    src_p0 = SRC_ZERO;
    if (aligned_p0 && ram_hit_p0) begin
      src_p0 = SRC_RAM;
    end else if (aligned_p0 && mmio_hit_p0) begin
      src_p0 = SRC_MMIO;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM array: no reset so contents survive a reset pulse
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_q_p1;

  // Store port: write the addressed word on an aligned, in-range store.
  always_ff @(posedge clk) begin
    if (ram_we_p0) begin
      mem[idx_p0] <= WriteData;
    end
  end

  // Load port: read every cycle; the array still holds the pre-write word here,
  // so a same-cycle read and write of one word returns the old data.
  always_ff @(posedge clk) begin
    ram_q_p1 <= mem[idx_p0];
  end

  // ---------------------------------------------------------------------------
  // MMIO register block
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_q_p1;

`ifdef DATA_MEMORY_MMIO_EN
  localparam logic [7:0] OFF_CYCLES  = 8'h00;
  localparam logic [7:0] OFF_SCRATCH = 8'h04;
  localparam logic [7:0] OFF_STATUS  = 8'h08;

  logic [31:0] cycles_q;
  logic [31:0] scratch_q;
  logic        count_en_q;
  logic        mmio_wr_p0;
  logic [7:0]  offs_p0;
  logic [31:0] mmio_rdata_p0;

  assign offs_p0    = WriteAddress[7:0];
  assign mmio_wr_p0 = write_enable && aligned_p0 && mmio_hit_p0;
  assign err_clr_p0 = mmio_wr_p0 && (offs_p0 == OFF_STATUS) && WriteData[0];

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles_q <= 32'h0;
    end else if (count_en_q) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  // Writable MMIO registers; CYCLES and unused offsets ignore stores silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scratch_q  <= 32'h0;
      count_en_q <= RESET_COUNT_EN_VAL;
    end else if (mmio_wr_p0) begin
      case (offs_p0)
        OFF_SCRATCH: scratch_q  <= WriteData;
        OFF_STATUS:  count_en_q <= WriteData[1];
        default:     ;
      endcase
    end
  end

  // MMIO read mux; values are those present at the address edge.
  always_comb begin
    mmio_rdata_p0 = 32'h0;
    case (offs_p0)
      OFF_CYCLES:  mmio_rdata_p0 = cycles_q;
      OFF_SCRATCH: mmio_rdata_p0 = scratch_q;
      OFF_STATUS:  mmio_rdata_p0 = {30'h0, count_en_q, mem_error};
      default:     mmio_rdata_p0 = 32'h0;
    endcase
  end

  // Register the MMIO read data alongside the RAM read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_q_p1 <= 32'h0;
    end else begin
      mmio_q_p1 <= mmio_rdata_p0;
    end
  end
`else
  logic unused_cfg;

  assign err_clr_p0 = 1'b0;
  assign mmio_q_p1  = 32'h0;
  assign unused_cfg = RESET_COUNT_EN_VAL;
`endif

  // ---------------------------------------------------------------------------
  // Stage p1: registered read source and sticky fault flag
  // ---------------------------------------------------------------------------
  src_e src_p1;

  // Read-source register; resetting it to SRC_ZERO forces ReadData to 0 at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_p1 <= SRC_ZERO;
    end else begin
      src_p1 <= src_p0;
    end
  end

  // Sticky fault flag; a write-1-clear wins over a fault in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_error <= 1'b0;
    end else if (err_clr_p0) begin
      mem_error <= 1'b0;
    end else if (fault_p0) begin
      mem_error <= 1'b1;
    end
  end

  // Output mux driven only by registered state.
  always_comb begin
    ReadData = 32'h0;
    case (src_p1)
      SRC_RAM:  ReadData = ram_q_p1;
      SRC_MMIO: ReadData = mmio_q_p1;
      default:  ReadData = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed testbench for data_memory (MMIO checks compile in with DATA_MEMORY_MMIO_EN).
module tb_data_memory;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        mem_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_memory #(
    .DEPTH_WORDS       (DEPTH),
    .RESET_COUNT_EN_VAL(1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .write_enable(write_enable),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .mem_error   (mem_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One access: drive request, take the rising edge, return 1 time unit later.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    write_enable = we;
    WriteAddress = a;
    WriteData    = d;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b0;
    write_enable = 1'b0;
    WriteAddress = 32'h0;
    WriteData    = 32'h0;
    #12;
    check("rst_rdata", ReadData, 32'h0);
    check("rst_err", {31'h0, mem_error}, 32'h0);
    reset = 1'b1;

    // Basic store/load with 1-cycle latency.
    cyc(1'b1, 32'h10, 32'h0);
    cyc(1'b1, 32'h10, 32'h1234_5678);
    check("st10_old", ReadData, 32'h0);
    cyc(1'b0, 32'h10, 32'h0);
    check("ld10", ReadData, 32'h1234_5678);

    // Same-cycle read and write return old data.
    cyc(1'b1, 32'h20, 32'h1);
    cyc(1'b1, 32'h20, 32'hAAAA_5555);
    check("raw_old", ReadData, 32'h1);
    cyc(1'b0, 32'h20, 32'h0);
    check("raw_new", ReadData, 32'hAAAA_5555);

    // Misaligned access: reads are harmless, stores fault and are dropped.
    cyc(1'b1, 32'h0, 32'h1111_1111);
    check("err_clean", {31'h0, mem_error}, 32'h0);
    cyc(1'b0, 32'h402, 32'h0);
    check("rd402_data", ReadData, 32'h0);
    check("rd402_err", {31'h0, mem_error}, 32'h0);
    cyc(1'b1, 32'h402, 32'hBADB_AD01);
    check("st402_err", {31'h0, mem_error}, 32'h1);
    cyc(1'b0, 32'h0, 32'h0);
    check("st402_word0", ReadData, 32'h1111_1111);
    check("err_sticky", {31'h0, mem_error}, 32'h1);

    // Reset clears the flag but keeps RAM; then out-of-range store.
    pulse_reset();
    check("err_after_rst", {31'h0, mem_error}, 32'h0);
    cyc(1'b1, 32'(4 * DEPTH), 32'h2222_2222);
    check("st_oor_err", {31'h0, mem_error}, 32'h1);
    cyc(1'b0, 32'h0, 32'h0);
    check("st_oor_word0", ReadData, 32'h1111_1111);
    cyc(1'b1, 32'h12, 32'h3333_3333);
    cyc(1'b0, 32'h10, 32'h0);
    check("st12_word10", ReadData, 32'h1234_5678);
    cyc(1'b0, 32'h1000, 32'h0);
    check("rd_unmapped", ReadData, 32'h0);

`ifdef DATA_MEMORY_MMIO_EN
    // STATUS read with fault pending and counting on.
    cyc(1'b0, 32'hFFFF_FF08, 32'h0);
    check("status_rd", ReadData, 32'h3);
    // CYCLES from a fresh reset: read at 1st edge -> 0, 5 edges later -> 5.
    pulse_reset();
    cyc(1'b0, 32'hFFFF_FF00, 32'h0);
    check("cycles_0", ReadData, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h10, 32'h0);
    cyc(1'b0, 32'hFFFF_FF00, 32'h0);
    check("cycles_5", ReadData, 32'h5);
    // Stop counting: counter holds 7 after the STATUS write edge.
    cyc(1'b1, 32'hFFFF_FF08, 32'h0);
    cyc(1'b0, 32'hFFFF_FF00, 32'h0);
    check("cycles_stop_a", ReadData, 32'h7);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h10, 32'h0);
    cyc(1'b0, 32'hFFFF_FF00, 32'h0);
    check("cycles_stop_b", ReadData, 32'h7);
    // Fault, then clear via STATUS bit0.
    cyc(1'b1, 32'hFFFF_FF0A, 32'h0);
    check("mmio_mis_err", {31'h0, mem_error}, 32'h1);
    cyc(1'b1, 32'hFFFF_FF08, 32'h1);
    check("w1c_clear", {31'h0, mem_error}, 32'h0);
    // SCRATCH round trip.
    cyc(1'b1, 32'hFFFF_FF04, 32'hDEAD_BEEF);
    cyc(1'b0, 32'hFFFF_FF04, 32'h0);
    check("scratch", ReadData, 32'hDEAD_BEEF);
    // Unused offset: write ignored without error, reads 0.
    cyc(1'b1, 32'hFFFF_FF0C, 32'h5A5A_5A5A);
    check("unused_err", {31'h0, mem_error}, 32'h0);
    cyc(1'b0, 32'hFFFF_FF0C, 32'h0);
    check("unused_rd", ReadData, 32'h0);
`else
    // MMIO page is unmapped in this build.
    pulse_reset();
    cyc(1'b0, 32'hFFFF_FF04, 32'h0);
    check("nommio_rd", ReadData, 32'h0);
    check("nommio_rd_err", {31'h0, mem_error}, 32'h0);
    cyc(1'b1, 32'hFFFF_FF08, 32'h1);
    check("nommio_wr_err", {31'h0, mem_error}, 32'h1);
`endif

    // Mid-stream asynchronous reset.
    cyc(1'b1, 32'h3, 32'h0);
    cyc(1'b0, 32'h10, 32'h0);
    check("pre_rst_data", ReadData, 32'h1234_5678);
    check("pre_rst_err", {31'h0, mem_error}, 32'h1);
    reset = 1'b0;
    #1;
    check("async_rst_data", ReadData, 32'h0);
    check("async_rst_err", {31'h0, mem_error}, 32'h0);
    reset = 1'b1;
    cyc(1'b0, 32'h10, 32'h0);
    check("ram_kept", ReadData, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
